// File: rtl/oled_ssd1331_pkg.sv
// Shared types, opcode table and argument-count lookup for the SSD1331 responder model.
package oled_ssd1331_pkg;

    localparam int unsigned X_W       = 7;
    localparam int unsigned Y_W       = 6;
    localparam int unsigned COLOR_W   = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ARG_CNT_W = 4;

    localparam logic [BYTE_W-1:0] OP_SET_COL     = 8'h15;
    localparam logic [BYTE_W-1:0] OP_SET_ROW     = 8'h75;
    localparam logic [BYTE_W-1:0] OP_DISP_OFF    = 8'hAE;
    localparam logic [BYTE_W-1:0] OP_DISP_ON     = 8'hAF;
    localparam logic [BYTE_W-1:0] OP_DRAW_LINE   = 8'h21;
    localparam logic [BYTE_W-1:0] OP_DRAW_RECT   = 8'h22;
    localparam logic [BYTE_W-1:0] OP_COPY        = 8'h23;
    localparam logic [BYTE_W-1:0] OP_SCROLL_SET  = 8'h27;
    localparam logic [BYTE_W-1:0] OP_GFX_FIRST   = 8'h21;
    localparam logic [BYTE_W-1:0] OP_GFX_LAST    = 8'h27;
    localparam logic [BYTE_W-1:0] OP_CONTR_FIRST = 8'h81;
    localparam logic [BYTE_W-1:0] OP_CONTR_LAST  = 8'h87;
    localparam logic [BYTE_W-1:0] OP_CFG_FIRST   = 8'hA0;
    localparam logic [BYTE_W-1:0] OP_CFG_LAST    = 8'hBE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COL_S,
        ST_COL_E,
        ST_ROW_S,
        ST_ROW_E,
        ST_SKIP
    } cmd_state_e;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    // Number of argument bytes that follow a listed opcode; unlisted opcodes take none.
    function automatic logic [ARG_CNT_W-1:0] cmd_arg_count(input logic [BYTE_W-1:0] op);
        logic [ARG_CNT_W-1:0] n;
        n = '0;
        if (op == OP_DRAW_LINE)         n = 4'd7;
        else if (op == OP_DRAW_RECT)    n = 4'd10;
        else if (op == OP_COPY)         n = 4'd6;
        else if (op == OP_SCROLL_SET)   n = 4'd5;
        else if ((op >= OP_CONTR_FIRST && op <= OP_CONTR_LAST) ||
                 (op >= OP_CFG_FIRST   && op <= OP_CFG_LAST)   ||
                 (op >= OP_GFX_FIRST   && op <= OP_GFX_LAST))
            n = 4'd1;
        return n;
    endfunction

endpackage

// File: rtl/oled_ssd1331_sink_if.sv
// SPI pins driven by the host plus the decoded byte/pixel stream presented by the sink.
interface oled_ssd1331_sink_if;
    import oled_ssd1331_pkg::*;

    logic               oled_csn;
    logic               oled_clk;
    logic               oled_mosi;
    logic               oled_dc;
    logic               oled_resn;
    logic               byte_valid;
    logic               byte_dc;
    logic [BYTE_W-1:0]  byte_data;
    logic               pixel_we;
    logic [X_W-1:0]     pixel_x;
    logic [Y_W-1:0]     pixel_y;
    logic [COLOR_W-1:0] pixel_color;
    logic               display_on;

    modport master (
        output oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
        input  byte_valid, byte_dc, byte_data, pixel_we, pixel_x, pixel_y, pixel_color, display_on
    );

    modport slave (
        input  oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
        output byte_valid, byte_dc, byte_data, pixel_we, pixel_x, pixel_y, pixel_color, display_on
    );

endinterface

// File: rtl/oled_ssd1331_sink_spi_byte_rx.sv
// Synchronises the SPI pins, detects SCLK rising edges and assembles MSB-first bytes.
module oled_ssd1331_sink_spi_byte_rx
    import oled_ssd1331_pkg::*;
#(
    parameter int unsigned C_SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csn_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    input  logic              dc_i,
    input  logic              panel_resn_i,
    output logic              csn_sync_o,
    output logic              soft_rst_o,
    output logic              byte_valid_o,
    output logic              byte_dc_o,
    output logic [BYTE_W-1:0] byte_data_o
);

    localparam int unsigned N_IN = 5;
    // Pin order {panel_resn, csn, sclk, mosi, dc}; idle levels keep the link deselected.
    localparam logic [N_IN-1:0] SYNC_RST = 5'b11000;

    logic [N_IN-1:0]   sync_q [C_SYNC_STAGES];
    logic [N_IN-1:0]   sync_w;
    logic              resn_s, csn_s, sclk_s, mosi_s, dc_s;
    logic              sclk_prev_q;
    logic              sclk_rise;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic              valid_q, valid_d;
    logic              dc_q, dc_d;
    logic [BYTE_W-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {panel_resn_i, csn_i, sclk_i, mosi_i, dc_i};
            for (int i = 1; i < C_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_w    = sync_q[C_SYNC_STAGES-1];
    assign resn_s    = sync_w[4];
    assign csn_s     = sync_w[3];
    assign sclk_s    = sync_w[2];
    assign mosi_s    = sync_w[1];
    assign dc_s      = sync_w[0];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        dc_d      = dc_q;
        data_d    = data_q;
        if (!resn_s) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            dc_d      = 1'b0;
            data_d    = '0;
        end else if (csn_s) begin
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            shift_d   = {shift_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                valid_d = 1'b1;
                dc_d    = dc_s;
                data_d  = {shift_q, mosi_s};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            valid_q     <= 1'b0;
            dc_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            sclk_prev_q <= sclk_s;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            valid_q     <= valid_d;
            dc_q        <= dc_d;
            data_q      <= data_d;
        end
    end

    assign csn_sync_o   = csn_s;
    assign soft_rst_o   = ~resn_s;
    assign byte_valid_o = valid_q;
    assign byte_dc_o    = dc_q;
    assign byte_data_o  = data_q;

endmodule

// File: rtl/oled_ssd1331_sink.sv
// SSD1331 responder: command decoder, address window, cursor and RGB565 pixel pairing.
module oled_ssd1331_sink
    import oled_ssd1331_pkg::*;
#(
    parameter int unsigned C_WIDTH       = 96,
    parameter int unsigned C_HEIGHT      = 64,
    parameter int unsigned C_SYNC_STAGES = 2
) (
    input  logic           clk_25mhz,
    input  logic           resn,
    oled_ssd1331_sink_if.slave bus
);

    localparam logic [X_W-1:0] X_LAST = X_W'(C_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(C_HEIGHT - 1);

    logic              csn_sync, soft_rst, rx_valid, rx_dc;
    logic [BYTE_W-1:0] rx_data;

    oled_ssd1331_sink_spi_byte_rx #(
        .C_SYNC_STAGES (C_SYNC_STAGES)
    ) u_rx (
        .clk          (clk_25mhz),
        .rst_n        (resn),
        .csn_i        (bus.oled_csn),
        .sclk_i       (bus.oled_clk),
        .mosi_i       (bus.oled_mosi),
        .dc_i         (bus.oled_dc),
        .panel_resn_i (bus.oled_resn),
        .csn_sync_o   (csn_sync),
        .soft_rst_o   (soft_rst),
        .byte_valid_o (rx_valid),
        .byte_dc_o    (rx_dc),
        .byte_data_o  (rx_data)
    );

    cmd_state_e           state_q, state_d;
    logic [ARG_CNT_W-1:0] arg_cnt_q, arg_cnt_d;
    logic [X_W-1:0]       col_start_q, col_start_d, col_end_q, col_end_d, cur_x_q, cur_x_d;
    logic [Y_W-1:0]       row_start_q, row_start_d, row_end_q, row_end_d, cur_y_q, cur_y_d;
    logic                 phase_lo_q, phase_lo_d;
    logic [BYTE_W-1:0]    hi_byte_q, hi_byte_d;
    logic                 pix_we_q, pix_we_d;
    pixel_t               pix_q, pix_d;
    logic                 disp_on_q, disp_on_d;

    // Decode one received byte per strobe; data bytes pair into pixels and advance the cursor.
    always_comb begin
        state_d     = state_q;
        arg_cnt_d   = arg_cnt_q;
        col_start_d = col_start_q;
        col_end_d   = col_end_q;
        row_start_d = row_start_q;
        row_end_d   = row_end_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        phase_lo_d  = phase_lo_q;
        hi_byte_d   = hi_byte_q;
        pix_we_d    = 1'b0;
        pix_d       = pix_q;
        disp_on_d   = disp_on_q;

        if (soft_rst) begin
            state_d     = ST_IDLE;
            arg_cnt_d   = '0;
            col_start_d = '0;
            col_end_d   = X_LAST;
            row_start_d = '0;
            row_end_d   = Y_LAST;
            cur_x_d     = '0;
            cur_y_d     = '0;
            phase_lo_d  = 1'b0;
            hi_byte_d   = '0;
            pix_d       = '0;
            disp_on_d   = 1'b0;
        end else begin
            if (rx_valid && !rx_dc) begin
                phase_lo_d = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data == OP_SET_COL)       state_d = ST_COL_S;
                        else if (rx_data == OP_SET_ROW)  state_d = ST_ROW_S;
                        else if (rx_data == OP_DISP_ON)  disp_on_d = 1'b1;
                        else if (rx_data == OP_DISP_OFF) disp_on_d = 1'b0;
                        else begin
                            arg_cnt_d = cmd_arg_count(rx_data);
                            if (cmd_arg_count(rx_data) != '0) state_d = ST_SKIP;
                        end
                    end
                    ST_COL_S: begin
                        col_start_d = rx_data[X_W-1:0];
                        state_d     = ST_COL_E;
                    end
                    ST_COL_E: begin
                        col_end_d = rx_data[X_W-1:0];
                        cur_x_d   = col_start_q;
                        cur_y_d   = row_start_q;
                        state_d   = ST_IDLE;
                    end
                    ST_ROW_S: begin
                        row_start_d = rx_data[Y_W-1:0];
                        state_d     = ST_ROW_E;
                    end
                    ST_ROW_E: begin
                        row_end_d = rx_data[Y_W-1:0];
                        cur_x_d   = col_start_q;
                        cur_y_d   = row_start_q;
                        state_d   = ST_IDLE;
                    end
                    ST_SKIP: begin
                        arg_cnt_d = arg_cnt_q - ARG_CNT_W'(1);
                        if (arg_cnt_q <= ARG_CNT_W'(1)) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else if (rx_valid && rx_dc) begin
                state_d = ST_IDLE;
                if (!phase_lo_q) begin
                    hi_byte_d  = rx_data;
                    phase_lo_d = 1'b1;
                end else begin
                    phase_lo_d = 1'b0;
                    pix_we_d   = 1'b1;
                    pix_d      = '{x: cur_x_q, y: cur_y_q, color: {hi_byte_q, rx_data}};
                    if (cur_x_q == col_end_q || cur_x_q == X_LAST) begin
                        cur_x_d = col_start_q;
                        if (cur_y_q == row_end_q || cur_y_q == Y_LAST) cur_y_d = row_start_q;
                        else                                           cur_y_d = cur_y_q + Y_W'(1);
                    end else begin
                        cur_x_d = cur_x_q + X_W'(1);
                    end
                end
            end
            // Deselect abandons any half-received pixel.
            if (csn_sync) phase_lo_d = 1'b0;
        end
    end

    always_ff @(posedge clk_25mhz or negedge resn) begin
        if (!resn) begin
            state_q     <= ST_IDLE;
            arg_cnt_q   <= '0;
            col_start_q <= '0;
            col_end_q   <= X_LAST;
            row_start_q <= '0;
            row_end_q   <= Y_LAST;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            phase_lo_q  <= 1'b0;
            hi_byte_q   <= '0;
            pix_we_q    <= 1'b0;
            pix_q       <= '0;
            disp_on_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            arg_cnt_q   <= arg_cnt_d;
            col_start_q <= col_start_d;
            col_end_q   <= col_end_d;
            row_start_q <= row_start_d;
            row_end_q   <= row_end_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            phase_lo_q  <= phase_lo_d;
            hi_byte_q   <= hi_byte_d;
            pix_we_q    <= pix_we_d;
            pix_q       <= pix_d;
            disp_on_q   <= disp_on_d;
        end
    end

    assign bus.byte_valid  = rx_valid;
    assign bus.byte_dc     = rx_dc;
    assign bus.byte_data   = rx_data;
    assign bus.pixel_we    = pix_we_q;
    assign bus.pixel_x     = pix_q.x;
    assign bus.pixel_y     = pix_q.y;
    assign bus.pixel_color = pix_q.color;
    assign bus.display_on  = disp_on_q;

endmodule

// File: tb/tb_oled_ssd1331_sink.sv
// Scoreboard bench: SPI driver queues expected bytes/pixels, a negedge monitor pops and compares.
module tb_oled_ssd1331_sink;

    typedef struct packed {
        logic [6:0]  x;
        logic [5:0]  y;
        logic [15:0] c;
    } exp_pix_t;

    logic clk = 1'b0;
    logic resn;

    always #20 clk = ~clk;

    oled_ssd1331_sink_if bus ();

    oled_ssd1331_sink #(
        .C_WIDTH       (96),
        .C_HEIGHT      (64),
        .C_SYNC_STAGES (2)
    ) dut (
        .clk_25mhz (clk),
        .resn      (resn),
        .bus       (bus)
    );

    int       nvec  = 0;
    int       nfail = 0;
    exp_pix_t pix_q[$];
    logic [8:0] byte_q[$];
    logic     mon_en  = 1'b0;
    logic     prev_bv = 1'b0;
    exp_pix_t e_pix;
    logic [8:0] e_byte;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every byte strobe and pixel strobe is matched against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.byte_valid) begin
                nvec++;
                if (byte_q.size() == 0) begin
                    nfail++;
                    $display("FAIL byte_unexpected: got dc=%0b data=%h expected none", bus.byte_dc, bus.byte_data);
                end else begin
                    e_byte = byte_q.pop_front();
                    if ({bus.byte_dc, bus.byte_data} !== e_byte) begin
                        nfail++;
                        $display("FAIL byte: got dc=%0b data=%h expected dc=%0b data=%h",
                                 bus.byte_dc, bus.byte_data, e_byte[8], e_byte[7:0]);
                    end
                end
            end
            if (bus.pixel_we) begin
                check("pixel_trails_data_byte", {30'd0, prev_bv, bus.byte_valid}, 32'd2);
                nvec++;
                if (pix_q.size() == 0) begin
                    nfail++;
                    $display("FAIL pixel_unexpected: got (%0d,%0d,%h) expected none",
                             bus.pixel_x, bus.pixel_y, bus.pixel_color);
                end else begin
                    e_pix = pix_q.pop_front();
                    if ({bus.pixel_x, bus.pixel_y, bus.pixel_color} !== e_pix) begin
                        nfail++;
                        $display("FAIL pixel: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                                 bus.pixel_x, bus.pixel_y, bus.pixel_color, e_pix.x, e_pix.y, e_pix.c);
                    end
                end
            end
        end
        prev_bv <= bus.byte_valid && bus.byte_dc;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SPI mode 0 at clk/4: two system cycles low with data set up, two high.
    task automatic send_bits(input logic dc, input logic [7:0] d, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            bus.oled_clk  = 1'b0;
            bus.oled_mosi = d[i];
            bus.oled_dc   = dc;
            repeat (2) @(negedge clk);
            bus.oled_clk = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        bus.oled_clk = 1'b0;
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] d);
        byte_q.push_back({dc, d});
        send_bits(dc, d, 8);
    endtask

    task automatic send_pixel(input logic [15:0] c, input logic [6:0] x, input logic [5:0] y);
        pix_q.push_back('{x: x, y: y, c: c});
        send_byte(1'b1, c[15:8]);
        send_byte(1'b1, c[7:0]);
    endtask

    task automatic set_window(input logic [7:0] cs, input logic [7:0] ce,
                              input logic [7:0] rs, input logic [7:0] re);
        send_byte(1'b0, 8'h15);
        send_byte(1'b0, cs);
        send_byte(1'b0, ce);
        send_byte(1'b0, 8'h75);
        send_byte(1'b0, rs);
        send_byte(1'b0, re);
    endtask

    initial begin
        resn          = 1'b0;
        bus.oled_csn  = 1'b1;
        bus.oled_clk  = 1'b0;
        bus.oled_mosi = 1'b0;
        bus.oled_dc   = 1'b0;
        bus.oled_resn = 1'b1;
        idle(4);
        check("rst_byte_valid",  {31'd0, bus.byte_valid}, 32'd0);
        check("rst_byte_data",   {24'd0, bus.byte_data},  32'd0);
        check("rst_pixel_we",    {31'd0, bus.pixel_we},   32'd0);
        check("rst_pixel_x",     {25'd0, bus.pixel_x},    32'd0);
        check("rst_pixel_y",     {26'd0, bus.pixel_y},    32'd0);
        check("rst_pixel_color", {16'd0, bus.pixel_color}, 32'd0);
        check("rst_display_on",  {31'd0, bus.display_on}, 32'd0);
        resn = 1'b1;
        idle(4);
        mon_en = 1'b1;
        bus.oled_csn = 1'b0;
        idle(4);

        // Two pixels from the power-on cursor.
        send_pixel(16'hF800, 7'd0, 6'd0);
        send_pixel(16'h07E0, 7'd1, 6'd0);

        // 2x2 window at (16..17, 5..6) wraps back to its origin.
        set_window(8'h10, 8'h11, 8'h05, 8'h06);
        send_pixel(16'h1111, 7'd16, 6'd5);
        send_pixel(16'h2222, 7'd17, 6'd5);
        send_pixel(16'h3333, 7'd16, 6'd6);
        send_pixel(16'h4444, 7'd17, 6'd6);
        send_pixel(16'h5555, 7'd16, 6'd5);

        // 0xAF right after 0x81 is its argument, not a display-on command.
        send_byte(1'b0, 8'h81);
        send_byte(1'b0, 8'hAF);
        idle(8);
        check("disp_after_arg", {31'd0, bus.display_on}, 32'd0);
        send_byte(1'b0, 8'hAF);
        idle(8);
        check("disp_on", {31'd0, bus.display_on}, 32'd1);
        send_byte(1'b0, 8'hAE);
        idle(8);
        check("disp_off", {31'd0, bus.display_on}, 32'd0);

        // Partial byte abandoned by deselect.
        send_bits(1'b1, 8'hF8, 4);
        bus.oled_csn = 1'b1;
        idle(6);
        bus.oled_csn = 1'b0;
        idle(4);
        send_pixel(16'h1234, 7'd17, 6'd5);

        // Start > end window wraps only at the panel edges.
        set_window(8'h5E, 8'h03, 8'h3E, 8'h01);
        send_pixel(16'hA001, 7'd94, 6'd62);
        send_pixel(16'hA002, 7'd95, 6'd62);
        send_pixel(16'hA003, 7'd94, 6'd63);
        send_pixel(16'hA004, 7'd95, 6'd63);
        send_pixel(16'hA005, 7'd94, 6'd62);

        // Full-width band of rows 61..63, ending at (95,63) then wrapping to the band origin.
        set_window(8'h00, 8'h5F, 8'h3D, 8'h3F);
        for (int i = 0; i < 289; i++) begin
            int k;
            k = i % 288;
            send_pixel(16'(i * 37 + 5), 7'(k % 96), 6'(61 + k / 96));
        end

        // Soft reset mid-frame from cursor (40,20) with a custom window and display on.
        send_byte(1'b0, 8'hAF);
        set_window(8'h1E, 8'h32, 8'h14, 8'h1E);
        for (int i = 0; i < 10; i++) send_pixel(16'(16'hC000 + i), 7'(30 + i), 6'd20);
        idle(8);
        check("disp_before_softrst", {31'd0, bus.display_on}, 32'd1);
        bus.oled_resn = 1'b0;
        idle(10);
        bus.oled_resn = 1'b1;
        idle(6);
        check("softrst_display_on",  {31'd0, bus.display_on},  32'd0);
        check("softrst_pixel_x",     {25'd0, bus.pixel_x},     32'd0);
        check("softrst_pixel_y",     {26'd0, bus.pixel_y},     32'd0);
        check("softrst_pixel_color", {16'd0, bus.pixel_color}, 32'd0);
        check("softrst_byte_data",   {24'd0, bus.byte_data},   32'd0);
        for (int i = 0; i < 52; i++) send_pixel(16'(16'hD000 + i), 7'(i), 6'd0);

        for (int t = 0; t < 2000 && (pix_q.size() != 0 || byte_q.size() != 0); t++) @(negedge clk);
        check("pix_queue_drained",  32'(pix_q.size()),  32'd0);
        check("byte_queue_drained", 32'(byte_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
